// File: rtl/sar_ctrl_fsm.sv
// Successive-approximation ADC controller: waits for the analog front end, tracks
// the input for a fixed window, then resolves one bit per trial from MSB to LSB.
module sar_ctrl_fsm #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SAMPLE_CYCLES = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             comp_i,
  input  logic             analog_ready_i,
  input  logic             trigger_i,
  input  logic             interrupt_clear_i,
  output logic             sample_o,
  output logic [WIDTH-1:0] dac_code_o,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o,
  output logic             irq_o,
  output logic             overrun_o
);

  localparam int unsigned IW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READY,
    SAMPLE,
    CONVERT,
    DONE
  } state_t;

  state_t           state;
  logic [7:0]       samp_cnt;
  logic [3:0]       settle_cnt;
  logic [IW-1:0]    bit_idx;
  logic [WIDTH-1:0] trial_code;

  // Code after resolving the current bit and arming the next lower trial bit.
  always_comb begin
    trial_code          = dac_code_o;
    trial_code[bit_idx] = comp_i;
    if (bit_idx != '0) begin
      trial_code[bit_idx - IW'(1)] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      sample_o   <= 1'b0;
      dac_code_o <= '0;
      result_o   <= '0;
      busy_o     <= 1'b0;
      irq_o      <= 1'b0;
      overrun_o  <= 1'b0;
      samp_cnt   <= '0;
      settle_cnt <= '0;
      bit_idx    <= '0;
    end else begin
      // Clear is applied first so a completion on the same edge overrides it.
      if (interrupt_clear_i) begin
        irq_o     <= 1'b0;
        overrun_o <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (trigger_i) begin
            state  <= WAIT_READY;
            busy_o <= 1'b1;
          end
        end
        WAIT_READY: begin
          if (analog_ready_i) begin
            state    <= SAMPLE;
            sample_o <= 1'b1;
            samp_cnt <= 8'(SAMPLE_CYCLES - 1);
          end
        end
        SAMPLE: begin
          if (!analog_ready_i) begin
            state    <= WAIT_READY;
            sample_o <= 1'b0;
          end else if (samp_cnt == '0) begin
            state      <= CONVERT;
            sample_o   <= 1'b0;
            dac_code_o <= WIDTH'(1) << (WIDTH - 1);
            bit_idx    <= IW'(WIDTH - 1);
            settle_cnt <= 4'(SETTLE_CYCLES);
          end else begin
            samp_cnt <= samp_cnt - 8'd1;
          end
        end
        CONVERT: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end else begin
            dac_code_o <= trial_code;
            if (bit_idx == '0) begin
              state    <= DONE;
              result_o <= trial_code;
              irq_o    <= 1'b1;
              if (irq_o) begin
                overrun_o <= 1'b1;
              end
            end else begin
              bit_idx    <= bit_idx - IW'(1);
              settle_cnt <= 4'(SETTLE_CYCLES);
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          dac_code_o <= '0;
          busy_o     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_ctrl_fsm.sv
// Scoreboard bench for sar_ctrl_fsm: default 8-bit instance with a comparator model,
// plus a 4-bit, no-settle, single-sample instance.
module tb_sar_ctrl_fsm;

  typedef struct {
    logic [7:0] res;
    int         fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  exp_t       sb[$];

  // 8-bit instance
  logic       ready8 = 1'b1, trig8 = 1'b0, clear8 = 1'b0;
  logic       use_model = 1'b0, comp_const = 1'b1;
  logic [7:0] vin8 = '0;
  logic       comp8;
  logic       sample8, busy8, irq8, ovr8;
  logic [7:0] dac8, result8;

  // 4-bit instance
  logic       trig4 = 1'b0;
  logic       comp4 = 1'b0, ready4 = 1'b1, clear4 = 1'b0;
  logic       sample4, busy4, irq4, ovr4;
  logic [3:0] dac4, result4;

  assign comp8 = use_model ? (vin8 >= dac8) : comp_const;

  sar_ctrl_fsm #(.WIDTH(8), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(1)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .comp_i(comp8), .analog_ready_i(ready8),
    .trigger_i(trig8), .interrupt_clear_i(clear8), .sample_o(sample8),
    .dac_code_o(dac8), .result_o(result8), .busy_o(busy8), .irq_o(irq8),
    .overrun_o(ovr8)
  );

  sar_ctrl_fsm #(.WIDTH(4), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(0)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .comp_i(comp4), .analog_ready_i(ready4),
    .trigger_i(trig4), .interrupt_clear_i(clear4), .sample_o(sample4),
    .dac_code_o(dac4), .result_o(result4), .busy_o(busy4), .irq_o(irq4),
    .overrun_o(ovr4)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drives a one-cycle trigger, queues the expected result; returns at the
  // negedge right after the trigger-sampling edge.
  task automatic start8(input logic [7:0] vin, input bit lat_check, output int tedge);
    exp_t e;
    @(negedge clk);
    vin8  = vin;
    trig8 = 1'b1;
    tedge = cyc + 1;
    e.res  = use_model ? vin : {8{comp_const}};
    e.fall = lat_check ? tedge + 22 : -1;
    sb.push_back(e);
    @(negedge clk);
    trig8 = 1'b0;
  endtask

  task automatic wait_idle8();
    for (int i = 0; i < 300 && busy8; i++) @(negedge clk);
    check("busy_timeout", 32'(busy8), 32'd0);
    @(negedge clk);
  endtask

  task automatic clear_irq8();
    @(negedge clk);
    clear8 = 1'b1;
    @(negedge clk);
    clear8 = 1'b0;
    check("clr_irq", 32'(irq8), 32'd0);
    check("clr_ovr", 32'(ovr8), 32'd0);
  endtask

  // Monitor: pops the scoreboard when the 8-bit instance returns to IDLE.
  initial begin
    logic bprev, sprev;
    int   srun, slast;
    exp_t e;
    bprev = 1'b0; sprev = 1'b0; srun = 0; slast = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bprev = 1'b0; sprev = 1'b0; srun = 0;
      end else begin
        if (sample8) srun = sprev ? srun + 1 : 1;
        if (!sample8 && sprev) slast = srun;
        if (bprev && !busy8) begin
          check("sb_pending", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("result", 32'(result8), 32'(e.res));
            check("sample_len", 32'(slast), 32'd4);
            if (e.fall >= 0) check("done_cycle", 32'(cyc), 32'(e.fall));
          end
        end
        bprev = busy8;
        sprev = sample8;
      end
    end
  end

  initial begin
    int         tedge;
    logic [7:0] seq[8];
    seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    // Reset state
    #2;
    check("rst_sample", 32'(sample8), 32'd0);
    check("rst_dac", 32'(dac8), 32'd0);
    check("rst_result", 32'(result8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_irq", 32'(irq8), 32'd0);
    check("rst_ovr", 32'(ovr8), 32'd0);
    check("rst4_busy", 32'(busy4), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // comp held 1: all-ones result, irq latency 21
    use_model = 1'b0; comp_const = 1'b1;
    start8(8'h00, 1'b1, tedge);
    for (int i = 0; i < 60 && !irq8; i++) @(negedge clk);
    check("irq_latency", 32'(cyc - tedge), 32'd21);
    check("busy_in_done", 32'(busy8), 32'd1);
    wait_idle8();
    check("idle_dac", 32'(dac8), 32'd0);

    // Comparator model with Vin = 0xA5: trial code sequence
    clear_irq8();
    use_model = 1'b1;
    start8(8'hA5, 1'b1, tedge);
    for (int k = 0; k < 8; k++) begin
      while (cyc < tedge + 5 + 2 * k) @(negedge clk);
      check("dac_seq", 32'(dac8), 32'(seq[k]));
    end
    wait_idle8();

    // Ready low holds WAIT_READY; ready dropping in SAMPLE aborts
    clear_irq8();
    ready8 = 1'b0;
    start8(8'h3C, 1'b0, tedge);
    repeat (5) @(negedge clk);
    check("wait_busy", 32'(busy8), 32'd1);
    check("wait_sample", 32'(sample8), 32'd0);
    ready8 = 1'b1;
    for (int i = 0; i < 10 && !sample8; i++) @(negedge clk);
    check("sample_start", 32'(sample8), 32'd1);
    @(negedge clk);
    ready8 = 1'b0;
    @(negedge clk);
    check("abort_sample", 32'(sample8), 32'd0);
    check("abort_busy", 32'(busy8), 32'd1);
    ready8 = 1'b1;
    wait_idle8();

    // Overrun and clear/set priority
    clear_irq8();
    start8(8'h11, 1'b1, tedge);
    wait_idle8();
    check("irq_first", 32'(irq8), 32'd1);
    check("ovr_first", 32'(ovr8), 32'd0);
    start8(8'h22, 1'b1, tedge);
    while (cyc < tedge + 20) @(negedge clk);
    clear8 = 1'b1;
    @(negedge clk);
    clear8 = 1'b0;
    check("set_wins_irq", 32'(irq8), 32'd1);
    check("set_wins_ovr", 32'(ovr8), 32'd1);
    clear8 = 1'b1;
    @(negedge clk);
    clear8 = 1'b0;
    check("cleared_irq", 32'(irq8), 32'd0);
    check("cleared_ovr", 32'(ovr8), 32'd0);
    wait_idle8();

    // Reset during the third bit trial
    start8(8'h77, 1'b0, tedge);
    while (cyc < tedge + 9) @(negedge clk);
    sb.delete();
    rst_n = 1'b0;
    #1;
    check("arst_sample", 32'(sample8), 32'd0);
    check("arst_dac", 32'(dac8), 32'd0);
    check("arst_result", 32'(result8), 32'd0);
    check("arst_busy", 32'(busy8), 32'd0);
    check("arst_irq", 32'(irq8), 32'd0);
    check("arst_ovr", 32'(ovr8), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start8(8'h5A, 1'b1, tedge);
    wait_idle8();

    // 4-bit, no settle, single sample cycle, comp held 0
    @(negedge clk);
    trig4 = 1'b1;
    tedge = cyc + 1;
    @(negedge clk);
    trig4 = 1'b0;
    for (int i = 0; i < 40 && !irq4; i++) @(negedge clk);
    check("irq4_latency", 32'(cyc - tedge), 32'd6);
    check("result4", 32'(result4), 32'd0);
    @(negedge clk);
    check("busy4_idle", 32'(busy4), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_ctrl_fsm.md
SAR_CTRL_FSM -- requirements
Module: sar_ctrl_fsm

Interface
REQ-001 Parameter WIDTH, default 8, conversion resolution in bits (legal 2..16).
REQ-002 Parameter SAMPLE_CYCLES, default 4, number of cycles sample_o is held high (legal 1..255).
REQ-003 Parameter SETTLE_CYCLES, default 1, extra DAC settling cycles per bit trial (legal 0..15).
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-006 comp_i  input  1  comparator output; 1 = analog input >= current DAC level.
REQ-007 analog_ready_i  input  1  analog front end powered and settled.
REQ-008 trigger_i  input  1  conversion request, level-sampled in IDLE.
REQ-009 interrupt_clear_i  input  1  clears irq_o and overrun_o.
REQ-010 sample_o  output  1  track/hold switch control; 1 = track.
REQ-011 dac_code_o  output  WIDTH  trial code driven to the capacitive DAC.
REQ-012 result_o  output  WIDTH  last completed conversion result.
REQ-013 busy_o  output  1  high in every state except IDLE.
REQ-014 irq_o  output  1  sticky conversion-complete interrupt.
REQ-015 overrun_o  output  1  sticky flag: a result completed while irq_o was still set.

Function
REQ-016 States SHALL be IDLE, WAIT_READY, SAMPLE, CONVERT, DONE, held in a registered state variable.
REQ-017 IDLE: trigger_i=1 at an edge SHALL move to WAIT_READY; otherwise the FSM stays in IDLE.
REQ-018 WAIT_READY: analog_ready_i=1 at an edge SHALL move to SAMPLE and load the sample counter; otherwise the FSM waits indefinitely.
REQ-019 SAMPLE: sample_o SHALL be 1 for exactly SAMPLE_CYCLES cycles, then the FSM SHALL move to CONVERT with dac_code_o = 1 << (WIDTH-1).
REQ-020 SAMPLE: analog_ready_i=0 at an edge SHALL abort to WAIT_READY with sample_o=0 and the sample counter reloaded on re-entry.
REQ-021 CONVERT: each bit trial SHALL last SETTLE_CYCLES+1 cycles, MSB first; comp_i is sampled only at the last edge of a trial.
REQ-022 At a trial's sampling edge: trial bit k <= comp_i; if k>0, bit k-1 <= 1; bits above k are unchanged.
REQ-023 At the LSB sampling edge the FSM SHALL enter DONE, with result_o <= final code, irq_o <= 1, and overrun_o <= 1 if irq_o was already 1.
REQ-024 DONE SHALL last one cycle and then return to IDLE with dac_code_o <= 0.
REQ-025 Latency: from the trigger-sampling edge to irq_o rising SHALL be 1 + SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) cycles when analog_ready_i is steady high.
REQ-026 analog_ready_i changes during CONVERT or DONE SHALL be ignored.
REQ-027 trigger_i outside IDLE SHALL be ignored; a trigger held high SHALL start back-to-back conversions, one IDLE cycle apart.
REQ-028 interrupt_clear_i=1 SHALL clear irq_o and overrun_o on the next edge; if it coincides with a set, the set wins.
REQ-029 result_o SHALL hold its value until the next DONE entry and is never cleared except by reset.
REQ-030 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Reset
REQ-031 rst_n_i=0 SHALL immediately force state=IDLE, sample_o=0, dac_code_o=0, result_o=0, busy_o=0, irq_o=0, overrun_o=0, and clear all counters.
REQ-032 Reset asserted mid-conversion SHALL discard the partial code; the first edge after deassertion evaluates IDLE normally.

Verification
REQ-033 Defaults; ready=1; trigger pulsed one cycle; comp_i held 1 -> result_o=0xFF; irq_o rises 21 cycles after the trigger edge; sample_o high for 4 cycles.
REQ-034 Defaults; comp_i modelled as (Vin >= dac_code_o) with Vin=0xA5 -> dac_code_o sequence 80,C0,A0,B0,A8,A4,A6,A5 (hex); result_o=0xA5.
REQ-035 ready=0; trigger -> FSM stays in WAIT_READY with busy_o=1 and sample_o=0; ready drops at SAMPLE cycle 2 -> back to WAIT_READY; ready restored -> 4 full sample cycles.
REQ-036 Two conversions without clear -> overrun_o=1 after the second; clear asserted on the second DONE-entry edge -> irq_o=1 and overrun_o=1 remain; clear next cycle -> both 0.
REQ-037 rst_n_i pulsed low during bit trial 3 -> all outputs 0 asynchronously; result_o=0; the next trigger converts correctly.
REQ-038 SETTLE_CYCLES=0, WIDTH=4, SAMPLE_CYCLES=1, comp_i held 0 -> result_o=0x0; irq_o 6 cycles after the trigger edge.
